datapath_sequencer: RTL
=======================

# datapath_sequencer

Multi-cycle control FSM that drives the register-file / ALU / data-memory datapath of `top_main`. It fetches 32-bit instructions from instruction memory, decodes them, and sequences these steps with ready-handshakes to both memories:

- register reads
- ALU execute
- data-memory access
- register write-back

It sits between the instruction memory and `top_main`, generating every address and enable that `top_main` consumes.

## Interface

Parameters:
- `PC_W`, 10: PC and address width; matches the datapath's 10-bit addresses.
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin execution from PC 0; sampled only in IDLE or DONE.
- `instr`  in  32  instruction word from instruction memory.
- `imem_ready`  in  1  `instr` is valid this cycle.
- `mem_ready`  in  1  data-memory read/write completes this cycle.
- `pc`  out  PC_W  instruction-memory address.
- `imem_req`  out  1  instruction fetch request.
- `reg1`, `reg2`  out  10  register read addresses.
- `write_address_reg`  out  10  register write address.
- `reg_we`  out  1  register-file write strobe, 1 cycle.
- `wb_sel`  out  1  write-back source: 0 = ALU, 1 = memory.
- `alu_en`  out  1  ALU evaluate strobe, 1 cycle.
- `address_mem`  out  10  data-memory address.
- `mem_re`, `mem_we`  out  1  data-memory read/write request.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  high in DONE.
- `retired`  out  CNT_W  count of completed instructions.

## Operation

Instruction format:
- `op`[31:30]
- `rd`[29:20]
- `rs1`[19:10]
- `rs2`/`addr`[9:0]

Opcodes:
- 00 ALU: rd ← rs1 op rs2.
- 01 LOAD: rd ← mem[addr].
- 10 STORE: mem[addr] ← rs1.
- 11 HALT.

States:
- IDLE → FETCH on `start`.
- FETCH: `imem_req`=1. Stays in FETCH while `imem_ready`=0. When `imem_ready`=1, `instr` is latched into the IR, `pc` ← `pc`+1 (wraps 1023→0), and the FSM goes to DECODE.
- DECODE (1 cycle): drives `reg1`=rs1, `reg2`=rs2, `write_address_reg`=rd. Next state by opcode: ALU→EXEC; LOAD/STORE→MEM; HALT→DONE.
- EXEC (1 cycle): `alu_en`=1 → WB.
- MEM:
  - LOAD drives `mem_re`=1; STORE drives `mem_we`=1.
  - `address_mem`=addr.
  - Stays in MEM while `mem_ready`=0.
  - When `mem_ready`=1: LOAD→WB; STORE retires and goes to FETCH.
- WB (1 cycle): `reg_we`=1, `wb_sel` per opcode; the instruction retires → FETCH.
- DONE: `done`=1. `start` clears `pc` to 0 and `retired` to 0, then → FETCH.

Rules:
- `retired` increments by 1 on each retire (WB exit, STORE MEM exit, HALT DECODE exit) and wraps at 2^CNT_W.
- `start` is ignored while `busy`.
- `reg1`, `reg2`, `write_address_reg` and `address_mem` hold the IR-derived values from DECODE until the next DECODE.
- All outputs are registered (Moore); no combinational path from input to output.

## Timing

- Reset values:
  - state = IDLE.
  - `pc`, `reg1`, `reg2`, `write_address_reg`, `address_mem`, `retired`, IR = 0.
  - All strobes, `wb_sel`, `busy`, `done` = 0.
- Reset is asynchronous and may occur in any state, including with a pending `imem_req` or `mem_re`/`mem_we`. The request drops immediately and the in-flight instruction is discarded: no `reg_we`, no retire.
- Latency with ready signals high on the first request cycle:
  - ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD: 4 cycles (FETCH, DECODE, MEM, WB).
  - STORE: 3 cycles (FETCH, DECODE, MEM).
  - HALT: 2 cycles to DONE.
- Each wait cycle on `imem_ready` or `mem_ready` adds exactly 1 cycle. Requests stay asserted, with stable addresses, until ready.
- A `mem_ready` or `imem_ready` arriving in any state other than the one that requested it is ignored.
- `reg_we` and `alu_en` are exactly 1-cycle pulses per instruction.
- `mem_re` and `mem_we` are never high together.

## Test plan

- **Reset, then ALU:** reset; `start`; `instr`=0x0030_0802 with `imem_ready` always 1.
  - Expect `reg1`=2, `reg2`=2, `write_address_reg`=3.
  - Expect `alu_en` in cycle 3 and `reg_we`=1 with `wb_sel`=0 in cycle 4.
  - Expect `pc`=1 and `retired`=1.
- **LOAD with stall:** op 01, rd=5, addr=0x3FF; `mem_ready` low for 3 cycles.
  - Expect `mem_re` held high for 4 cycles with `address_mem`=0x3FF.
  - Then WB with `wb_sel`=1 and `write_address_reg`=5; total 7 cycles.
- **STORE:** op 10, rs1=7, addr=9.
  - Expect `mem_we`=1 with `address_mem`=9 and `reg1`=7.
  - Expect no `reg_we`; 3-cycle retire.
- **HALT and restart:** ALU, STORE, HALT sequence.
  - Expect `done`=1, `busy`=0, `retired`=3.
  - `start` → `pc`=0, `retired`=0, FETCH.
  - `start` asserted while `busy` has no effect.
- **PC wrap:** preload via 1023 sequential ALU instructions, then one more fetch.
  - Expect `pc` to go 1023→0.
- **Reset mid-MEM:** assert `rst` during a stalled LOAD.
  - Expect `mem_re`=0 immediately, state IDLE, no `reg_we`, `retired` unchanged at reset value 0.

Source files
------------

// File: rtl/datapath_sequencer.sv
// Multi-cycle control FSM for the register-file / ALU / data-memory datapath.
// Fetches, decodes and sequences each instruction with ready handshakes; all outputs are flops.
module datapath_sequencer #(
  parameter int unsigned PC_W  = 10,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      instr,
  input  logic             imem_ready,
  input  logic             mem_ready,
  output logic [PC_W-1:0]  pc,
  output logic             imem_req,
  output logic [9:0]       reg1,
  output logic [9:0]       reg2,
  output logic [9:0]       write_address_reg,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             alu_en,
  output logic [9:0]       address_mem,
  output logic             mem_re,
  output logic             mem_we,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExec, StMem, StWb, StDone
  } state_e;

  localparam logic [1:0] OpAlu   = 2'b00;
  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpStore = 2'b10;

  state_e           state_q, state_d;
  logic [1:0]       op_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] retired_q;
  logic [9:0]       reg1_q, reg2_q, wr_addr_q, addr_mem_q;
  logic             imem_req_q, reg_we_q, wb_sel_q, alu_en_q;
  logic             mem_re_q, mem_we_q, busy_q, done_q;
  logic             fetch_ok, retire, restart;

  assign fetch_ok = (state_q == StFetch) && imem_ready;
  assign restart  = ((state_q == StIdle) || (state_q == StDone)) && start;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = StFetch;
      StFetch:        if (imem_ready) state_d = StDecode;
      StDecode: begin
        case (op_q)
          OpAlu:           state_d = StExec;
          OpLoad, OpStore: state_d = StMem;
          default: begin
            state_d = StDone;
            retire  = 1'b1;
          end
        endcase
      end
      StExec: state_d = StWb;
      StMem: begin
        if (mem_ready) begin
          if (op_q == OpLoad) begin
            state_d = StWb;
          end else begin
            state_d = StFetch;
            retire  = 1'b1;
          end
        end
      end
      StWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand fields are captured on fetch accept so they are already valid during DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q       <= '0;
      pc_q       <= '0;
      retired_q  <= '0;
      reg1_q     <= '0;
      reg2_q     <= '0;
      wr_addr_q  <= '0;
      addr_mem_q <= '0;
    end else begin
      if (restart) begin
        pc_q      <= '0;
        retired_q <= '0;
      end else begin
        if (fetch_ok) pc_q <= pc_q + PC_W'(1);
        if (retire)   retired_q <= retired_q + CNT_W'(1);
      end
      if (fetch_ok) begin
        op_q       <= instr[31:30];
        wr_addr_q  <= instr[29:20];
        reg1_q     <= instr[19:10];
        reg2_q     <= instr[9:0];
        addr_mem_q <= instr[9:0];
      end
    end
  end

  // Strobes are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_req_q <= 1'b0;
      reg_we_q   <= 1'b0;
      wb_sel_q   <= 1'b0;
      alu_en_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      imem_req_q <= (state_d == StFetch);
      reg_we_q   <= (state_d == StWb);
      wb_sel_q   <= (state_d == StWb) && (op_q == OpLoad);
      alu_en_q   <= (state_d == StExec);
      mem_re_q   <= (state_d == StMem) && (op_q == OpLoad);
      mem_we_q   <= (state_d == StMem) && (op_q == OpStore);
      busy_q     <= (state_d != StIdle) && (state_d != StDone);
      done_q     <= (state_d == StDone);
    end
  end

  assign pc                = pc_q;
  assign imem_req          = imem_req_q;
  assign reg1              = reg1_q;
  assign reg2              = reg2_q;
  assign write_address_reg = wr_addr_q;
  assign reg_we            = reg_we_q;
  assign wb_sel            = wb_sel_q;
  assign alu_en            = alu_en_q;
  assign address_mem       = addr_mem_q;
  assign mem_re            = mem_re_q;
  assign mem_we            = mem_we_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign retired           = retired_q;

endmodule
